// File: rtl/fp_pkg.sv
// Shared floating-point definitions: rounding modes, flag bit positions and
// exponent helpers used by the multiplier back end and the rounding helper.
package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_t;

  // Bit positions inside the 3-bit {overflow, underflow, inexact} flag vector
  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned fp_exp_max(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_round_inc.sv
// Round-increment decision from {lsb, guard, sticky, sign} under the run-time
// rounding mode; kept separate so the adder datapath can share it.
module fp_round_inc
  import fp_pkg::*;
(
  input  logic lsb_i,
  input  logic guard_i,
  input  logic sticky_i,
  input  logic sign_i,
  input  rm_t  rm_i,
  output logic inc_o
);

  always_comb begin
    inc_o = 1'b0;
    case (rm_i)
      RM_RNE: inc_o = guard_i & (sticky_i | lsb_i);
      RM_RTZ: inc_o = 1'b0;
      RM_RDN: inc_o = sign_i & (guard_i | sticky_i);
      RM_RUP: inc_o = ~sign_i & (guard_i | sticky_i);
      default: inc_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_norm_round_pipe.sv
// 3-stage normalise / round / pack back end of the FP multiplier, valid/ready on both sides.
// Define FP_NORM_SUBNORM_EN for gradual underflow; otherwise tiny results flush to signed zero.
module fp_norm_round_pipe
  import fp_pkg::*;
#(
  parameter  int MANT_W = 24,
  parameter  int EXP_W  = 8,
  localparam int SHW    = $clog2(2*MANT_W+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*MANT_W-1:0]      in_mant,
  input  logic [SHW-1:0]           in_lzc,
  input  logic signed [EXP_W+1:0]  in_exp_sum,
  input  logic                     in_sign,
  input  logic [1:0]               in_rm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MANT_W-1:0]  out_result,
  output logic [2:0]               out_flags
);

  localparam int PW = 2*MANT_W;
  localparam int EW = EXP_W + 3;  // one spare bit so e_n never wraps for any lzc
  localparam int FW = MANT_W - 1;
  localparam logic [EW-1:0]    EMAX = EW'(fp_exp_max(EXP_W));
  localparam logic [EXP_W-1:0] EFIN = EXP_W'(fp_exp_max(EXP_W) - 1);

  logic rdy1, rdy2, rdy3;
  logic v1_q, v2_q, v3_q;

  logic [PW-1:0] m1_d, m1_q;
  logic [EW-1:0] e1_d, e1_q;
  logic          z1_d, z1_q, s1_q;
  rm_t           rm1_q;

  logic                tiny2_d, fl2_d, nx2_d, inc, g2, st2, lost;
  logic [PW-1:0]       sh_m;
  logic [MANT_W-1:0]   sig;
  logic [MANT_W:0]     sig_r;
  logic [EW-1:0]       e2_d, e2_q;
  logic [FW-1:0]       f2_d, f2_q;
  logic                s2_q, nx2_q, tiny2_q, z2_q, fl2_q;
  rm_t                 rm2_q;

  logic                    ovf3, to_inf;
  logic [EXP_W+FW:0]       res3_d, res3_q;
  logic [2:0]              flg3_d, flg3_q;

  always_comb begin
    rdy3 = !v3_q || out_ready;
    rdy2 = !v2_q || rdy3;
    rdy1 = !v1_q || rdy2;
  end

  assign in_ready   = rdy1;
  assign out_valid  = v3_q;
  assign out_result = res3_q;
  assign out_flags  = flg3_q;

  always_comb begin
    m1_d = in_mant << in_lzc;
    e1_d = EW'(in_exp_sum) + EW'(1) - EW'(in_lzc);
    z1_d = (in_mant == '0);
  end

  assign tiny2_d = e1_q[EW-1] | (e1_q == '0);

`ifdef FP_NORM_SUBNORM_EN
  logic [EW-1:0]   neg_e, sh_amt;
  logic [2*PW-1:0] wide;

  // Denormalise by 1-e_n; the low half of the wide shifter collects the bits that fall off.
  always_comb begin
    neg_e  = '0 - e1_q;
    sh_amt = '0;
    if (tiny2_d)
      sh_amt = (neg_e >= EW'(MANT_W)) ? EW'(MANT_W + 1) : neg_e + EW'(1);
    wide  = {m1_q, {PW{1'b0}}} >> sh_amt;
    sh_m  = wide[2*PW-1:PW];
    lost  = |wide[PW-1:0];
    fl2_d = 1'b0;
  end
`else
  always_comb begin
    sh_m  = m1_q;
    lost  = 1'b0;
    fl2_d = tiny2_d & ~z1_q;
  end
`endif

  fp_round_inc u_round (
    .lsb_i    (sig[0]),
    .guard_i  (g2),
    .sticky_i (st2),
    .sign_i   (s1_q),
    .rm_i     (rm1_q),
    .inc_o    (inc)
  );

  // Subnormals never carry out of MANT_W bits; rounding into the hidden bit gives exp field 1.
  always_comb begin
    sig   = sh_m[PW-1 -: MANT_W];
    g2    = sh_m[PW-1-MANT_W];
    st2   = (|sh_m[PW-2-MANT_W:0]) | lost;
    sig_r = {1'b0, sig} + {{MANT_W{1'b0}}, inc};
    f2_d  = sig_r[FW-1:0];
    nx2_d = g2 | st2;
    if (tiny2_d)
      e2_d = {{(EW-1){1'b0}}, sig_r[MANT_W-1]};
    else
      e2_d = e1_q + {{(EW-1){1'b0}}, sig_r[MANT_W]};
  end

  always_comb begin
    ovf3   = !e2_q[EW-1] && (e2_q >= EMAX);
    to_inf = (rm2_q == RM_RNE) || (rm2_q == RM_RUP && !s2_q) || (rm2_q == RM_RDN && s2_q);
    res3_d = {s2_q, e2_q[EXP_W-1:0], f2_q};
    flg3_d = '0;
    flg3_d[FLAG_NX] = nx2_q;
    flg3_d[FLAG_UF] = tiny2_q & nx2_q;
    if (z2_q) begin
      res3_d = {s2_q, {(EXP_W+FW){1'b0}}};
      flg3_d = '0;
    end else if (fl2_q) begin
      res3_d = {s2_q, {(EXP_W+FW){1'b0}}};
      flg3_d = '0;
      flg3_d[FLAG_UF] = 1'b1;
      flg3_d[FLAG_NX] = 1'b1;
    end else if (ovf3) begin
      res3_d = to_inf ? {s2_q, {EXP_W{1'b1}}, {FW{1'b0}}} : {s2_q, EFIN, {FW{1'b1}}};
      flg3_d = '0;
      flg3_d[FLAG_OF] = 1'b1;
      flg3_d[FLAG_NX] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      m1_q    <= '0;
      e1_q    <= '0;
      z1_q    <= 1'b0;
      s1_q    <= 1'b0;
      rm1_q   <= RM_RNE;
      e2_q    <= '0;
      f2_q    <= '0;
      s2_q    <= 1'b0;
      nx2_q   <= 1'b0;
      tiny2_q <= 1'b0;
      z2_q    <= 1'b0;
      fl2_q   <= 1'b0;
      rm2_q   <= RM_RNE;
      res3_q  <= '0;
      flg3_q  <= '0;
    end else begin
      if (rdy1) v1_q <= in_valid;
      if (rdy2) v2_q <= v1_q;
      if (rdy3) v3_q <= v2_q;
      if (rdy1 && in_valid) begin
        m1_q  <= m1_d;
        e1_q  <= e1_d;
        z1_q  <= z1_d;
        s1_q  <= in_sign;
        rm1_q <= rm_t'(in_rm);
      end
      if (rdy2 && v1_q) begin
        e2_q    <= e2_d;
        f2_q    <= f2_d;
        s2_q    <= s1_q;
        nx2_q   <= nx2_d;
        tiny2_q <= tiny2_d;
        z2_q    <= z1_q;
        fl2_q   <= fl2_d;
        rm2_q   <= rm1_q;
      end
      if (rdy3 && v2_q) begin
        res3_q <= res3_d;
        flg3_q <= flg3_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Scoreboard bench for fp_norm_round_pipe (MANT_W=24, EXP_W=8) with hand-computed single-precision vectors.
module tb_fp_norm_round_pipe;
  import fp_pkg::*;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;
  localparam int SHW    = $clog2(2*MANT_W+1);

`ifdef FP_NORM_SUBNORM_EN
  localparam logic [31:0] SUB_R  = 32'h00400000;
  localparam logic [2:0]  SUB_F  = 3'b000;
  localparam logic [31:0] HID_R  = 32'h00800000;
  localparam logic [31:0] DUP_R  = 32'h00000001;
`else
  localparam logic [31:0] SUB_R  = 32'h00000000;
  localparam logic [2:0]  SUB_F  = 3'b011;
  localparam logic [31:0] HID_R  = 32'h00000000;
  localparam logic [31:0] DUP_R  = 32'h00000000;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [2*MANT_W-1:0]     in_mant;
  logic [SHW-1:0]          in_lzc;
  logic signed [EXP_W+1:0] in_exp_sum;
  logic                    in_sign;
  logic [1:0]              in_rm;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_result;
  logic [2:0]              out_flags;

  always #5 clk = ~clk;

  fp_norm_round_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_lzc     (in_lzc),
    .in_exp_sum (in_exp_sum),
    .in_sign    (in_sign),
    .in_rm      (in_rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int accepted = 0;
  int stalls   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send(input logic [47:0] m, input int lz, input int es, input logic sg,
                      input rm_t rm, input logic [31:0] r, input logic [2:0] f,
                      input int lat, input string nm);
    exp_t e;
    int   waited;
    waited     = 0;
    in_valid   = 1'b1;
    in_mant    = m;
    in_lzc     = SHW'(lz);
    in_exp_sum = (EXP_W+2)'(es);
    in_sign    = sg;
    in_rm      = rm;
    @(negedge clk);
    while (!in_ready) begin
      waited++;
      stalls++;
      if (waited > 100) begin
        bad++;
        total++;
        $display("FAIL in_ready_timeout: actual=stalled required=accept (%s)", nm);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "input handshake timed out");
      end
      @(negedge clk);
    end
    e.res     = r;
    e.flg     = f;
    e.lat     = lat;
    e.acc_cyc = cyc;
    e.name    = nm;
    sb.push_back(e);
    accepted++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops expected beats on each output transfer and checks hold-stability under stall
  initial begin : monitor
    exp_t        e;
    logic        held;
    logic [34:0] held_val;
    held     = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (held && out_valid)
        chk("hold_stable", 64'({out_result, out_flags}), 64'(held_val));
      held     = out_valid && !out_ready && !rst;
      held_val = {out_result, out_flags};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: actual=%h required=no_beat", out_result);
        end else begin
          e = sb.pop_front();
          chk(e.name, 64'({out_result, out_flags}), 64'({e.res, e.flg}));
          if (e.lat > 0)
            chk({e.name, "_latency"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int base;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_mant    = '0;
    in_lzc     = '0;
    in_exp_sum = '0;
    in_sign    = 1'b0;
    in_rm      = 2'b00;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid",  64'(out_valid),  64'd0);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk("reset_out_flags",  64'(out_flags),  64'd0);
    chk("reset_in_ready",   64'(in_ready),   64'd1);
    @(posedge clk);
    #1;

    send(48'h600000_000000, 1, 127, 1'b0, RM_RNE, 32'h3FC00000, 3'b000, 3, "mul_1p5");
    wait_drain("drain_first");

    stalls = 0;
    send(48'h800001_800000, 0, 126, 1'b0, RM_RNE, 32'h3F800002, 3'b001, 0, "tie_rne");
    send(48'h800001_800000, 0, 126, 1'b0, RM_RTZ, 32'h3F800001, 3'b001, 0, "tie_rtz");
    send(48'h800001_800000, 0, 126, 1'b1, RM_RDN, 32'hBF800002, 3'b001, 0, "tie_rdn_neg");
    send(48'h800001_800000, 0, 126, 1'b0, RM_RUP, 32'h3F800002, 3'b001, 0, "tie_rup_pos");
    send(48'h800001_800000, 0, 126, 1'b1, RM_RUP, 32'hBF800001, 3'b001, 0, "tie_rup_neg");
    send(48'h800000_000000, 0, 254, 1'b0, RM_RNE, 32'h7F800000, 3'b101, 0, "ovf_rne");
    send(48'h800000_000000, 0, 254, 1'b0, RM_RTZ, 32'h7F7FFFFF, 3'b101, 0, "ovf_rtz");
    send(48'h800000_000000, 0, 254, 1'b0, RM_RDN, 32'h7F7FFFFF, 3'b101, 0, "ovf_rdn_pos");
    send(48'h800000_000000, 0, 254, 1'b1, RM_RDN, 32'hFF800000, 3'b101, 0, "ovf_rdn_neg");
    send(48'h800000_000000, 0, 253, 1'b0, RM_RNE, 32'h7F000000, 3'b000, 0, "max_normal_exp");
    send(48'hFFFFFF_800000, 0, 126, 1'b0, RM_RNE, 32'h40000000, 3'b001, 0, "round_carry");
    send(48'hFFFFFF_800000, 0, 253, 1'b0, RM_RNE, 32'h7F800000, 3'b101, 0, "carry_to_ovf");
    send(48'h000000_000000, 0,   5, 1'b1, RM_RNE, 32'h80000000, 3'b000, 0, "zero_neg");
    send(48'h800000_000000, 0,  -1, 1'b0, RM_RNE, SUB_R,        SUB_F,  0, "subnormal");
    send(48'hFFFFFF_000000, 0,  -1, 1'b0, RM_RNE, HID_R,        3'b011, 0, "sub_round_hidden");
    send(48'h800000_000000, 0, -100, 1'b0, RM_RNE, 32'h00000000, 3'b011, 0, "deep_under_rne");
    send(48'h800000_000000, 0, -100, 1'b0, RM_RUP, DUP_R,        3'b011, 0, "deep_under_rup");
    chk("stream_stalls", 64'(stalls), 64'd0);
    wait_drain("drain_stream");

    base = accepted;
    fork
      begin
        send(48'h600000_000000, 1, 127, 1'b0, RM_RNE, 32'h3FC00000, 3'b000, 0, "bp0");
        send(48'h800001_800000, 0, 126, 1'b0, RM_RNE, 32'h3F800002, 3'b001, 0, "bp1");
        send(48'h800001_800000, 0, 126, 1'b0, RM_RTZ, 32'h3F800001, 3'b001, 0, "bp2");
        send(48'h800000_000000, 0, 254, 1'b0, RM_RTZ, 32'h7F7FFFFF, 3'b101, 0, "bp3");
        send(48'hFFFFFF_800000, 0, 126, 1'b0, RM_RNE, 32'h40000000, 3'b001, 0, "bp4");
        send(48'h000000_000000, 0,   5, 1'b1, RM_RNE, 32'h80000000, 3'b000, 0, "bp5");
      end
      begin
        out_ready = 1'b0;
        repeat (6) @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_accepted", 64'(accepted - base), 64'd3);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_backpressure");

    out_ready = 1'b0;
    send(48'h800001_800000, 0, 126, 1'b0, RM_RNE, 32'h3F800002, 3'b001, 0, "rst_drop0");
    send(48'h800001_800000, 0, 126, 1'b0, RM_RTZ, 32'h3F800001, 3'b001, 0, "rst_drop1");
    send(48'h600000_000000, 1, 127, 1'b0, RM_RNE, 32'h3FC00000, 3'b000, 0, "rst_drop2");
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_no_output", 64'(out_valid), 64'd0);
    end
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    send(48'h800000_000000, 0, 254, 1'b1, RM_RTZ, 32'hFF7FFFFF, 3'b101, 3, "after_rst");
    wait_drain("drain_after_rst");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
